alu_vector_checker: RTL and testbench
=====================================

Name: alu_vector_checker

Overview:
- Hardware self-checking engine for the ALU: it drives a stored test vector onto the ALU inputs and compares the ALU response against the expected fields.
- Vectors arrive one at a time on a valid/ready stream, using the same 104-bit packing the ALU bench uses: {ALUControl, a, b, Result, ALUFlags}, right-aligned.
- The block counts mismatches, records the first failing index, and reports pass/fail.
- It sits between a vector ROM/FIFO and a combinational alu instance, so ALU regression runs on-chip.

Parameters:
- VEC_W, 104, vector word width; bits [103:102] are ignored.
- CNT_W, 16, width of the vector count, index and error counters.
- SETTLE, 1, cycles the ALU inputs are held before sampling; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
- num_vecs  in  CNT_W  number of vectors in the run; sampled on an accepted start.
- vec_valid  in  1  vec_data holds a valid vector.
- vec_data  in  VEC_W  [101:100] ALUControl, [99:68] a, [67:36] b, [35:4] expected Result, [3:0] expected flags NZCV.
- vec_ready  out  1  checker accepts vec_data this cycle.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_ctrl  out  2  ALU ALUControl.
- alu_result  in  32  ALU Result.
- alu_flags  in  4  ALU ALUFlags.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  CNT_W  mismatching vectors; saturates at all-ones.
- first_err_idx  out  CNT_W  index of the first mismatching vector.
- first_err_valid  out  1  first_err_idx is meaningful.
- mismatch_pulse  out  1  one-cycle strobe in the CHECK cycle of a failing vector.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - All outputs and internal registers clear to 0, including alu_a/alu_b/alu_ctrl, vec_ready, busy, done, pass, err_count, first_err_idx, first_err_valid, mismatch_pulse.
  - Reset asserted mid-run abandons the run immediately; no partial results are retained.
- FSM states: IDLE, FETCH, APPLY, CHECK, DONE.
- IDLE / DONE on start=1:
  - Latch num_vecs.
  - Clear idx, err_count, first_err_idx, first_err_valid, done and pass.
  - If num_vecs==0, go to DONE with done=1, pass=1 on the next edge. Otherwise go to FETCH with busy=1.
- FETCH:
  - vec_ready=1 (combinational from state only).
  - On vec_valid&vec_ready, register ctrl/a/b/exp_result/exp_flags, load settle counter with SETTLE, and go to APPLY.
  - With vec_valid=0, stay in FETCH indefinitely; counters are unchanged.
- APPLY:
  - alu_a/alu_b/alu_ctrl are driven from the registered vector and stay stable until the next accepted vector.
  - The settle counter decrements each cycle; at 1, go to CHECK.
  - Exactly SETTLE cycles are spent in APPLY.
- CHECK:
  - Compare alu_result==exp_result and alu_flags==exp_flags, both 4 flag bits exact.
  - On mismatch:
    - mismatch_pulse=1 for this cycle only.
    - err_count increments, saturating.
    - If first_err_valid==0, set first_err_idx=idx and first_err_valid=1.
  - Then idx increments.
  - If the new idx==num_vecs, go to DONE, with busy=0, done=1 and pass=(final err_count==0) from the next cycle. Otherwise go to FETCH.
- Throughput: SETTLE+2 cycles per vector when vec_valid is continuously high. A run of N vectors takes N*(SETTLE+2) cycles from the first accepted vector to done.
- DONE:
  - Outputs hold.
  - The ALU drive registers hold the last vector.
  - A new start restarts the run as from IDLE.
- start during FETCH/APPLY/CHECK is ignored with no side effects.
- Each vec_data word is consumed exactly once.

Test Plan:
1. Reset: hold reset_n=0 with start=1 and vec_valid=1 -> all outputs 0, vec_ready=0. After release, state is IDLE.
2. Passing run, SETTLE=1, num_vecs=2:
   - vec0 = {00, 0x00000001, 0x00000002, 0x00000003, 0x0} (ADD).
   - vec1 = {01, 0x00000005, 0x00000005, 0x00000000, 0x6} (SUB; Z,C set).
   - Connect a correct alu.
   - Expected: done=1 and pass=1 exactly 6 cycles after the first accept; err_count=0; first_err_valid=0; alu_a==5 in DONE.
3. Mismatch: 3 vectors, vec1 expects Result 0x00000004 for 1+2 -> single mismatch_pulse in vec1's CHECK cycle; err_count=1; first_err_idx=1; first_err_valid=1; pass=0 at done.
4. Stream stall: vec_valid low for 5 cycles in FETCH -> vec_ready stays 1, alu outputs unchanged, no count change; the run completes once valid returns.
5. num_vecs=0 -> done=1 and pass=1 one cycle after start; vec_ready never asserts. A start pulse during busy in another run -> ignored, no count reset.
6. Reset mid-run: assert reset_n=0 during APPLY of vec1 -> all outputs 0 asynchronously. A new start after release runs cleanly with err_count starting at 0.

Source files
------------

// File: rtl/alu_vector_checker.sv
// On-chip ALU regression engine: streams in packed test vectors, drives them onto a
// combinational ALU, and compares the ALU's result and flags against the expected fields.
module alu_vector_checker #(
  parameter int unsigned VEC_W  = 104,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vecs,
  input  logic             vec_valid,
  input  logic [VEC_W-1:0] vec_data,
  output logic             vec_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic [3:0]       alu_flags,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_valid,
  output logic             mismatch_pulse
);

  typedef enum logic [2:0] {StIdle, StFetch, StApply, StCheck, StDone} state_e;

  localparam logic [3:0]       SettleInit = 4'(SETTLE);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             first_vld_q, first_vld_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      exp_res_q, exp_res_d;
  logic [3:0]       exp_flags_q, exp_flags_d;
  logic [3:0]       settle_q, settle_d;

  logic             mismatch;
  logic [CNT_W-1:0] idx_inc;
  logic [CNT_W-1:0] err_next;
  logic             unused_pad;

  // Top pad bits of the vector word carry no information.
  assign unused_pad = ^vec_data[VEC_W-1:102];

  assign mismatch = (state_q == StCheck) &&
                    ((alu_result != exp_res_q) || (alu_flags != exp_flags_q));
  assign idx_inc  = idx_q + CNT_W'(1);
  assign err_next = (mismatch && (err_q != CntMax)) ? err_q + CNT_W'(1) : err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      num_q       <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      exp_res_q   <= '0;
      exp_flags_q <= '0;
      settle_q    <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      exp_res_q   <= exp_res_d;
      exp_flags_q <= exp_flags_d;
      settle_q    <= settle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    idx_d       = idx_q;
    err_d       = err_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    done_d      = done_q;
    pass_d      = pass_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    exp_res_d   = exp_res_q;
    exp_flags_d = exp_flags_q;
    settle_d    = settle_q;
    unique case (state_q)
      StIdle, StDone: begin
        // ALU drive registers deliberately keep the last vector across a restart.
        if (start) begin
          num_d       = num_vecs;
          idx_d       = '0;
          err_d       = '0;
          first_idx_d = '0;
          first_vld_d = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          if (num_vecs == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (vec_valid) begin
          ctrl_d      = vec_data[101:100];
          a_d         = vec_data[99:68];
          b_d         = vec_data[67:36];
          exp_res_d   = vec_data[35:4];
          exp_flags_d = vec_data[3:0];
          settle_d    = SettleInit;
          state_d     = StApply;
        end
      end
      StApply: begin
        settle_d = settle_q - 4'd1;
        if (settle_q <= 4'd1) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        err_d = err_next;
        if (mismatch && !first_vld_q) begin
          first_idx_d = idx_q;
          first_vld_d = 1'b1;
        end
        idx_d = idx_inc;
        if (idx_inc == num_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vec_ready      = (state_q == StFetch);
    busy           = (state_q == StFetch) || (state_q == StApply) || (state_q == StCheck);
    mismatch_pulse = mismatch;
  end

  assign alu_a           = a_q;
  assign alu_b           = b_q;
  assign alu_ctrl        = ctrl_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_idx   = first_idx_q;
  assign first_err_valid = first_vld_q;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Directed bench for alu_vector_checker with a behavioural ALU (ADD/SUB/AND/OR, NZCV flags).
module tb_alu_vector_checker;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [15:0]  num_vecs;
  logic         vec_valid;
  logic [103:0] vec_data;
  logic         vec_ready;
  logic [31:0]  alu_a, alu_b, alu_result;
  logic [1:0]   alu_ctrl;
  logic [3:0]   alu_flags;
  logic         busy, done, pass, first_err_valid, mismatch_pulse;
  logic [15:0]  err_count, first_err_idx;

  alu_vector_checker dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .num_vecs        (num_vecs),
    .vec_valid       (vec_valid),
    .vec_data        (vec_data),
    .vec_ready       (vec_ready),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_ctrl        (alu_ctrl),
    .alu_result      (alu_result),
    .alu_flags       (alu_flags),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_idx   (first_err_idx),
    .first_err_valid (first_err_valid),
    .mismatch_pulse  (mismatch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU; C is carry-out (no borrow) for SUB, C/V cleared for logic ops.
  logic [32:0] sum33;
  always_comb begin
    sum33 = alu_ctrl[0] ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1) : ({1'b0, alu_a} + {1'b0, alu_b});
    case (alu_ctrl)
      2'b10:   alu_result = alu_a & alu_b;
      2'b11:   alu_result = alu_a | alu_b;
      default: alu_result = sum33[31:0];
    endcase
    alu_flags[3] = alu_result[31];
    alu_flags[2] = (alu_result == 32'd0);
    alu_flags[1] = ~alu_ctrl[1] & sum33[32];
    alu_flags[0] = ~alu_ctrl[1] & ~(alu_a[31] ^ alu_b[31] ^ alu_ctrl[0]) & (alu_a[31] ^ sum33[31]);
  end

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    logic        exp_pass;
  } vec_t;

  vec_t         tbl [8];
  logic [103:0] feed_mem [8];
  int           feed_n, feed_idx;
  logic         feed_en;
  int           n_checks, n_fail;
  int           pulse_cnt, pulse_feed;
  int           cyc;

  function automatic logic [103:0] pack(input vec_t v);
    return {2'b11, v.ctrl, v.a, v.b, v.res, v.flg};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_feed();
    vec_valid = feed_en && (feed_idx < feed_n);
    vec_data  = (feed_idx < feed_n) ? feed_mem[feed_idx] : '0;
  endtask

  // Always called at a negedge; advances one full cycle.
  task automatic tick();
    logic acc;
    acc = vec_valid && vec_ready;
    if (mismatch_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_feed = feed_idx;
    end
    @(negedge clk);
    if (acc) feed_idx++;
    drive_feed();
  endtask

  task automatic start_run(input logic [15:0] n);
    pulse_cnt = 0;
    start     = 1'b1;
    num_vecs  = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int c);
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic load2(input vec_t v0, input vec_t v1, input int n);
    feed_mem[0] = pack(v0);
    feed_mem[1] = pack(v1);
    feed_n      = n;
    feed_idx    = 0;
    feed_en     = 1'b1;
    drive_feed();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; pulse_cnt = 0; pulse_feed = 0;
    feed_n = 0; feed_idx = 0; feed_en = 1'b0;
    tbl[0] = '{2'b00, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'h0, 1'b1};
    tbl[1] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'h6, 1'b1};
    tbl[2] = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'h9, 1'b1};
    tbl[3] = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'h8, 1'b1};
    tbl[4] = '{2'b10, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'h0, 1'b1};
    tbl[5] = '{2'b11, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'h8, 1'b1};
    tbl[6] = '{2'b00, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'h2, 1'b0};
    tbl[7] = '{2'b01, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'h4, 1'b0};

    // Reset with start and valid held high
    reset_n = 1'b0; start = 1'b1; num_vecs = 16'd3; vec_valid = 1'b1; vec_data = '1;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({vec_ready, busy, done, pass, mismatch_pulse, first_err_valid, alu_ctrl}),
          64'd0);
    check("rst_ab", {alu_a, alu_b}, 64'd0);
    check("rst_cnt", 64'({err_count, first_err_idx}), 64'd0);
    start = 1'b0;
    reset_n = 1'b1;
    drive_feed();
    tick();
    check("idle_after_rst", 64'({vec_ready, busy, done}), 64'd0);

    // Passing two-vector run with latency check
    begin
      vec_t v0, v1;
      v0 = '{2'b00, 32'h1, 32'h2, 32'h3, 4'h0, 1'b1};
      v1 = '{2'b01, 32'h5, 32'h5, 32'h0, 4'h6, 1'b1};
      load2(v0, v1, 2);
    end
    start_run(16'd2);
    check("run_busy", 64'({busy, vec_ready}), 64'b11);
    wait_done("pass_run_done", 20, cyc);
    check("pass_run_latency", 64'(cyc), 64'd6);
    check("pass_run_res", 64'({pass, first_err_valid, busy, vec_ready}), 64'b1000);
    check("pass_run_err", 64'(err_count), 64'd0);
    check("pass_run_alu", 64'({alu_ctrl, alu_a}), {30'd0, 2'b01, 32'd5});

    // Table of single-vector runs
    for (int i = 0; i < 8; i++) begin
      load2(tbl[i], tbl[i], 1);
      start_run(16'd1);
      wait_done($sformatf("tbl%0d_done", i), 20, cyc);
      check($sformatf("tbl%0d_pass", i), 64'(pass), 64'(tbl[i].exp_pass));
      check($sformatf("tbl%0d_err", i), 64'(err_count), 64'(!tbl[i].exp_pass));
      check($sformatf("tbl%0d_pulses", i), 64'(pulse_cnt), 64'(!tbl[i].exp_pass));
      check($sformatf("tbl%0d_drive", i), {alu_a, alu_b ^ {30'd0, alu_ctrl}},
            {tbl[i].a, tbl[i].b ^ {30'd0, tbl[i].ctrl}});
    end

    // Three vectors, middle one expects a wrong sum
    feed_mem[0] = pack(tbl[0]);
    feed_mem[1] = pack('{2'b00, 32'h1, 32'h2, 32'h4, 4'h0, 1'b0});
    feed_mem[2] = pack('{2'b01, 32'h5, 32'h5, 32'h0, 4'h6, 1'b1});
    feed_n = 3; feed_idx = 0; feed_en = 1'b1; drive_feed();
    start_run(16'd3);
    wait_done("mm_done", 30, cyc);
    check("mm_latency", 64'(cyc), 64'd9);
    check("mm_pulse_cnt", 64'(pulse_cnt), 64'd1);
    check("mm_pulse_at_vec1", 64'(pulse_feed), 64'd2);
    check("mm_err", 64'({err_count, first_err_idx}), {32'd0, 16'd1, 16'd1});
    check("mm_flags", 64'({first_err_valid, pass}), 64'b10);

    // Stream stall in FETCH before the second vector
    load2(tbl[4], tbl[5], 2);
    start_run(16'd2);
    cyc = 0;
    while (!(feed_idx == 1 && vec_ready === 1'b1) && cyc < 10) begin
      tick();
      cyc++;
    end
    check("stall_reach_fetch", 64'({feed_idx[0], vec_ready}), 64'b11);
    feed_en = 1'b0;
    drive_feed();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_hold%0d", i),
            {alu_a ^ {16'd0, err_count}, 28'd0, vec_ready, busy, alu_ctrl},
            {tbl[4].a, 28'd0, 1'b1, 1'b1, tbl[4].ctrl});
    end
    check("stall_no_accept", 64'(feed_idx), 64'd1);
    feed_en = 1'b1;
    drive_feed();
    wait_done("stall_done", 20, cyc);
    check("stall_result", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});
    check("stall_consumed", 64'(feed_idx), 64'd2);

    // Empty run
    feed_n = 0; feed_idx = 0; drive_feed();
    start_run(16'd0);
    check("empty_done", 64'({done, pass, busy, vec_ready}), 64'b1100);

    // Start ignored while busy
    load2(tbl[6], tbl[0], 2);
    start_run(16'd2);
    cyc = 0;
    while (err_count !== 16'd1 && cyc < 20) begin
      tick();
      cyc++;
    end
    start = 1'b1;
    num_vecs = 16'd5;
    tick();
    start = 1'b0;
    check("ign_start_busy", 64'({busy, err_count}), {47'd0, 1'b1, 16'd1});
    wait_done("ign_done", 20, cyc);
    check("ign_result", 64'({pass, first_err_valid, first_err_idx, err_count}),
          {30'd0, 1'b0, 1'b1, 16'd0, 16'd1});
    check("ign_consumed", 64'(feed_idx), 64'd2);

    // Asynchronous reset during APPLY of vec1
    load2(tbl[6], tbl[0], 2);
    start_run(16'd2);
    cyc = 0;
    while (!(feed_idx == 2 && busy === 1'b1 && vec_ready === 1'b0) && cyc < 20) begin
      tick();
      cyc++;
    end
    check("mid_pre_err", 64'(err_count), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ctl", 64'({vec_ready, busy, done, pass, mismatch_pulse, first_err_valid,
                              alu_ctrl}), 64'd0);
    check("mid_rst_data", {alu_a | alu_b, 16'd0, err_count | first_err_idx}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    feed_mem[0] = pack(tbl[3]);
    feed_n = 1; feed_idx = 0; feed_en = 1'b1; drive_feed();
    start_run(16'd1);
    check("post_rst_err0", 64'(err_count), 64'd0);
    wait_done("post_rst_done", 20, cyc);
    check("post_rst_result", 64'({pass, err_count}), {47'd0, 1'b1, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
